// File: rtl/deser_sequencer.sv
// Frame sequencer: steers val/rdy words into 1<<dec_in external capture registers
// and hands the full frame downstream. Optional macro DESER_SEQ_BYPASS_EN removes the per-frame bubble.
module deser_sequencer #(
  parameter int dec_in = 1,
  parameter int regs   = 1 << dec_in,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_val,
  output logic              rec_rdy,
  output logic              send_val,
  input  logic              send_rdy,
  input  logic              clear,
  output logic              EN,
  output logic [dec_in-1:0] dec_select,
  output logic [regs-1:0]   dec_out,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam logic [dec_in-1:0] LAST_IDX = dec_in'(regs - 1);

  state_t            r_st;
  state_t            w_st_nxt;
  logic [dec_in-1:0] r_idx;
  logic [dec_in-1:0] w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st  <= ST_FILL;
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_idx <= w_idx_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case/if tree can leave a value unassigned and infer a latch.
  always_comb begin
    w_st_nxt   = r_st;
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    rec_rdy    = 1'b0;
    send_val   = 1'b0;
    dec_select = r_idx;
    if (reset) begin
      // Handshakes held low; the flops take their reset values on this edge.
    end else if (clear) begin
      w_st_nxt  = ST_FILL;
      w_idx_nxt = '0;
    end else begin
      case (r_st)
        ST_FILL: begin
          rec_rdy = 1'b1;
          if (rec_val) begin
            if (r_idx == LAST_IDX) begin
              w_idx_nxt = '0;
              w_st_nxt  = ST_FULL;
            end else begin
              w_idx_nxt = r_idx + dec_in'(1);
            end
          end
        end
        ST_FULL: begin
          send_val   = 1'b1;
          dec_select = '0;
`ifdef DESER_SEQ_BYPASS_EN
          rec_rdy    = send_rdy;
`endif
          if (send_rdy) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_st_nxt  = ST_FILL;
            w_idx_nxt = '0;
`ifdef DESER_SEQ_BYPASS_EN
            // First word of the next frame lands in register 0 on the delivery edge.
            if (rec_val) begin
              if (regs == 1) w_st_nxt = ST_FULL;
              else           w_idx_nxt = dec_in'(1);
            end
`endif
          end
        end
        default: begin
          w_st_nxt  = ST_FILL;
          w_idx_nxt = '0;
        end
      endcase
    end
  end

  assign EN        = rec_val & rec_rdy;
  assign dec_out   = EN ? (regs'(1) << dec_select) : '0;
  assign frame_cnt = r_cnt;

endmodule

// File: tb/tb_deser_sequencer.sv
// Scoreboard bench for deser_sequencer (regs=2, CNT_W=2 to exercise counter wrap).
// Bypass scenario compiled only with DESER_SEQ_BYPASS_EN.
module tb_deser_sequencer;

  localparam int DEC_IN = 1;
  localparam int REGS   = 2;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              rec_val;
  logic              rec_rdy;
  logic              send_val;
  logic              send_rdy;
  logic              clear;
  logic              EN;
  logic [DEC_IN-1:0] dec_select;
  logic [REGS-1:0]   dec_out;
  logic [CNT_W-1:0]  frame_cnt;

  typedef struct packed {
    logic [DEC_IN-1:0] sel;
    logic [REGS-1:0]   oh;
  } word_exp_t;

  word_exp_t        word_q[$];
  logic [CNT_W-1:0] frame_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;

  always #5 clk = ~clk;

  deser_sequencer #(.dec_in(DEC_IN), .regs(REGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rec_val(rec_val), .rec_rdy(rec_rdy),
    .send_val(send_val), .send_rdy(send_rdy), .clear(clear), .EN(EN),
    .dec_select(dec_select), .dec_out(dec_out), .frame_cnt(frame_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the rising edge, then park on the falling edge for checks.
  task automatic cyc(input logic rv, input logic sr, input logic clr);
    @(posedge clk);
    #1;
    rec_val  = rv;
    send_rdy = sr;
    clear    = clr;
    @(negedge clk);
  endtask

  task automatic exp_word(input int sel);
    word_exp_t w;
    w.sel = DEC_IN'(sel);
    w.oh  = REGS'(1 << sel);
    word_q.push_back(w);
  endtask

  task automatic exp_frame();
    exp_cnt = exp_cnt + CNT_W'(1);
    frame_q.push_back(exp_cnt);
  endtask

  // Two words, a bubble cycle, then the send handshake.
  task automatic send_frame();
    exp_word(0);
    exp_word(1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("frame_ready_send_val", 32'(send_val), 32'd1);
    check("frame_ready_rec_rdy", 32'(rec_rdy), 32'd0);
    exp_frame();
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT writes a word or delivers a frame.
  initial begin
    word_exp_t        w;
    logic [CNT_W-1:0] f;
    forever begin
      @(negedge clk);
      if (EN) begin
        if (word_q.size() == 0) begin
          check("unexpected_word_sel_oh", 32'({dec_select, dec_out}), 32'hFFFF_FFFF);
        end else begin
          w = word_q.pop_front();
          check("word_dec_select", 32'(dec_select), 32'(w.sel));
          check("word_dec_out", 32'(dec_out), 32'(w.oh));
        end
      end else begin
        check("idle_dec_out", 32'(dec_out), 32'd0);
      end
      if (send_val && send_rdy && !reset && !clear) begin
        if (frame_q.size() == 0) begin
          check("unexpected_frame_cnt", 32'(frame_cnt), 32'hFFFF_FFFF);
        end else begin
          f = frame_q.pop_front();
          @(posedge clk);
          #2;
          check("frame_cnt_after_send", 32'(frame_cnt), 32'(f));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    rec_val  = 1'b1;
    send_rdy = 1'b0;
    clear    = 1'b0;

    repeat (2) begin
      @(negedge clk);
      check("rst_rec_rdy", 32'(rec_rdy), 32'd0);
      check("rst_send_val", 32'(send_val), 32'd0);
      check("rst_en", 32'(EN), 32'd0);
      check("rst_dec_out", 32'(dec_out), 32'd0);
      check("rst_dec_select", 32'(dec_select), 32'd0);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    rec_val = 1'b0;
    @(negedge clk);
    check("post_rst_rec_rdy", 32'(rec_rdy), 32'd1);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("post_rst_send_val", 32'(send_val), 32'd0);

    // Frame 1: back-to-back words, then delivery.
    send_frame();
`ifndef DESER_SEQ_BYPASS_EN
    check("full_no_bypass_rec_rdy", 32'(rec_rdy), 32'd0);
`endif
    cyc(1'b0, 1'b0, 1'b0);
    check("after_send_rec_rdy", 32'(rec_rdy), 32'd1);
    check("after_send_send_val", 32'(send_val), 32'd0);

    // Frame 2: held for 5 cycles with upstream pushing.
    exp_word(0);
    exp_word(1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) begin
      cyc(1'b1, 1'b0, 1'b0);
      check("hold_send_val", 32'(send_val), 32'd1);
      check("hold_rec_rdy", 32'(rec_rdy), 32'd0);
      check("hold_en", 32'(EN), 32'd0);
    end
    exp_frame();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("hold_release_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Clear after one word: next word restarts at register 0.
    exp_word(0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    check("clear_rec_rdy", 32'(rec_rdy), 32'd0);
    check("clear_send_val", 32'(send_val), 32'd0);
    check("clear_en", 32'(EN), 32'd0);
    exp_word(0);
    exp_word(1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("refill_send_val", 32'(send_val), 32'd1);
    // Clear in FULL beats a simultaneous send_rdy.
    cyc(1'b0, 1'b1, 1'b1);
    check("clear_full_send_val", 32'(send_val), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("clear_full_state", 32'({send_val, rec_rdy}), 32'b01);
    check("clear_full_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Frames 3..5: counter wraps 3 -> 0 -> 1.
    repeat (3) send_frame();
    cyc(1'b0, 1'b0, 1'b0);
    check("wrap_cnt", 32'(frame_cnt), 32'd1);

`ifdef DESER_SEQ_BYPASS_EN
    // 8 words with no bubble; the 4th frame leaves on the cycle after.
    for (int i = 0; i < 8; i++) exp_word(i % 2);
    for (int i = 0; i < 4; i++) exp_frame();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      check("bypass_en", 32'(EN), 32'd1);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("bypass_cnt", 32'(frame_cnt), 32'(exp_cnt));
`endif

    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("word_q_drained", 32'(word_q.size()), 32'd0);
    check("frame_q_drained", 32'(frame_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
